m_csr_access_unit: RTL and testbench
====================================

// Module: m_csr_access_unit
// PURPOSE
//  Sequential CSR access controller in the EXE stage; parametrised successor to the combinational CSR R/W checker.
//  Decodes Zicsr ops, applies spec-correct rd/wr suppression, privilege and read-only legality checks,
//  and runs a req/ack transaction with the CSR file. Returns read data and the final RegWrite to MEM/WB.
//  Uses valid/ready on both sides; non-CSR instructions pass through in one cycle.
// PARAMETERS
//  XLEN         32  data width of rs1_data, csr_wdata, csr_rdata, out_rdata
//  ACK_TIMEOUT  8   max cycles in WAIT before an access fault; must be >=1; counter is $clog2(ACK_TIMEOUT+1) bits
// PORTS
//  clk           in   1     single clock; rising edge
//  rst           in   1     asynchronous, active-high reset
//  in_valid      in   1     ID/EXE holds a valid instruction
//  in_ready      out  1     unit accepts; high only in IDLE
//  instruction   in   32    raw instruction; rd=[11:7], rs1/uimm=[19:15], imm form=[14], csr_addr=[31:20]
//  csr_ops       in   2     00 none, 01 write, 10 set, 11 clear
//  rs1_data      in   XLEN  forwarded rs1 value
//  RegWrite_in   in   1     RegWrite from ID/EXE
//  priv_mode     in   2     current privilege (00 U, 01 S, 11 M)
//  csr_req_valid out  1     request to CSR file
//  csr_rd_req    out  1     read strobe, qualified by csr_req_valid
//  csr_wr_req    out  1     write strobe, qualified by csr_req_valid
//  csr_op        out  2     csr_ops of the request
//  csr_addr      out  12    CSR address
//  csr_wdata     out  XLEN  imm form ? zero-extended uimm : rs1_data
//  csr_ack       in   1     CSR file done; rdata valid the same cycle
//  csr_rdata     in   XLEN  CSR read value
//  out_valid     out  1     result valid to MEM
//  out_ready     in   1     MEM accepts
//  out_rdata     out  XLEN  CSR read value, or 0
//  out_RegWrite  out  1     final RegWrite
//  illegal_csr   out  1     illegal-instruction or access fault; qualified by out_valid
//  illegal_tval  out  32    offending instruction when illegal_csr=1, else 0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except in_ready=1; timeout counter cleared. Reset mid-transaction aborts it with no response.
//  Decode: WRITE -> rd_req=(rd!=0), wr_req=1. SET/CLEAR -> rd_req=1, wr_req=(rs1/uimm field!=0).
//  Legality: illegal if (wr_req && csr_addr[11:10]==2'b11) or (csr_addr[9:8] > priv_mode).
//   An illegal access never asserts csr_req_valid.
//  FSM IDLE->WAIT->RESP->IDLE:
//   IDLE: in_ready=1. Handshake is in_valid&&in_ready.
//    csr_ops==00: latch out_RegWrite=RegWrite_in, out_rdata=0, go RESP.
//    csr_ops!=00 and illegal: out_RegWrite=0, illegal_csr=1, go RESP.
//    csr_ops!=00 and legal: register request fields, go WAIT.
//   WAIT: csr_req_valid=1; request fields held stable; counter increments each cycle.
//    On csr_ack: out_rdata = rd_req ? csr_rdata : 0; out_RegWrite=(rd!=0); go RESP.
//    Counter reaches ACK_TIMEOUT without ack: illegal_csr=1, out_RegWrite=0, drop request, go RESP.
//    An ack in the timeout cycle wins over the timeout.
//   RESP: out_valid=1, outputs held until out_ready; then IDLE.
//  Latency: pass-through or illegal, out_valid 1 cycle after accept. Legal CSR access, out_valid 1 cycle after ack.
//  Throughput: one instruction in flight, which serialises all CSR side effects. csr_ack outside WAIT is ignored.
// CONFIGURATION
//  CSR_ACCESS_STATS_EN defined: adds outputs stat_access (32) and stat_illegal (32).
//   stat_access counts accepted csr_ops!=00; stat_illegal counts illegal_csr responses.
//   Both wrap at 2^32 and reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 CSRRW rd=x0, addr 0x340, M-mode, ack after 2 cycles -> csr_rd_req=0, csr_wr_req=1, out_RegWrite=0, out_valid 1 cycle after ack.
//  2 CSRRS rd=x5, rs1=x0, addr 0xC00, U-mode, rdata 0x1234 -> csr_wr_req=0, legal, out_rdata=0x1234, out_RegWrite=1.
//  3 CSRRW addr 0xC00 -> illegal_csr=1, illegal_tval=instruction, no csr_req_valid.
//    CSRRS addr 0x300 in U-mode -> illegal_csr=1.
//  4 Legal CSRRC, ack never arrives, ACK_TIMEOUT=8 -> illegal_csr=1 after 8 WAIT cycles.
//    Ack on the 8th cycle -> normal response.
//  5 Non-CSR op, RegWrite_in=1, out_ready low 3 cycles -> out_valid held 3 cycles, in_ready=0 until drained, out_RegWrite=1.
//  6 rst asserted in WAIT -> csr_req_valid and out_valid drop asynchronously; with _EN, counters reach 0.

Source files
------------

// File: rtl/m_csr_access_unit.sv
// Sequential Zicsr access controller for the EXE stage: decode, legality check, req/ack with the
// CSR file and a registered response to MEM. Optional CSR_ACCESS_STATS_EN adds access counters.
module m_csr_access_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [1:0]      csr_ops,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            RegWrite_in,
    input  logic [1:0]      priv_mode,
    output logic            csr_req_valid,
    output logic            csr_rd_req,
    output logic            csr_wr_req,
    output logic [1:0]      csr_op,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic            csr_ack,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_RegWrite,
    output logic            illegal_csr,
    output logic [31:0]     illegal_tval
`ifdef CSR_ACCESS_STATS_EN
    ,
    output logic [31:0]     stat_access,
    output logic [31:0]     stat_illegal
`endif
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            rd_nz_q;
    logic [31:0]     instr_q;

    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic            dec_imm;
    logic [11:0]     dec_addr;
    logic            dec_rd_req;
    logic            dec_wr_req;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_wdata;
    logic            accept;
    logic            timeout_fire;

    assign dec_rd   = instruction[11:7];
    assign dec_rs1  = instruction[19:15];
    assign dec_imm  = instruction[14];
    assign dec_addr = instruction[31:20];

    // CSRRW with rd=x0 must not read; CSRRS/C with rs1/uimm=0 must not write.
    always_comb begin
        dec_rd_req = 1'b1;
        dec_wr_req = (dec_rs1 != 5'd0);
        if (csr_ops == 2'b01) begin
            dec_rd_req = (dec_rd != 5'd0);
            dec_wr_req = 1'b1;
        end
    end

    assign dec_illegal = (dec_wr_req && (dec_addr[11:10] == 2'b11)) ||
                         (dec_addr[9:8] > priv_mode);
    assign dec_wdata   = dec_imm ? {{(XLEN-5){1'b0}}, dec_rs1} : rs1_data;

    assign accept       = in_valid && in_ready;
    assign timeout_fire = (state_q == StWait) && !csr_ack && (cnt_q == CntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rd_nz_q       <= 1'b0;
            instr_q       <= '0;
            in_ready      <= 1'b1;
            csr_req_valid <= 1'b0;
            csr_rd_req    <= 1'b0;
            csr_wr_req    <= 1'b0;
            csr_op        <= 2'b00;
            csr_addr      <= '0;
            csr_wdata     <= '0;
            out_valid     <= 1'b0;
            out_rdata     <= '0;
            out_RegWrite  <= 1'b0;
            illegal_csr   <= 1'b0;
            illegal_tval  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        instr_q  <= instruction;
                        if (csr_ops == 2'b00) begin
                            out_RegWrite <= RegWrite_in;
                            out_rdata    <= '0;
                            illegal_csr  <= 1'b0;
                            illegal_tval <= '0;
                            out_valid    <= 1'b1;
                            state_q      <= StResp;
                        end else if (dec_illegal) begin
                            out_RegWrite <= 1'b0;
                            out_rdata    <= '0;
                            illegal_csr  <= 1'b1;
                            illegal_tval <= instruction;
                            out_valid    <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            csr_req_valid <= 1'b1;
                            csr_rd_req    <= dec_rd_req;
                            csr_wr_req    <= dec_wr_req;
                            csr_op        <= csr_ops;
                            csr_addr      <= dec_addr;
                            csr_wdata     <= dec_wdata;
                            rd_nz_q       <= (dec_rd != 5'd0);
                            cnt_q         <= '0;
                            state_q       <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (csr_ack || timeout_fire) begin
                        csr_req_valid <= 1'b0;
                        csr_rd_req    <= 1'b0;
                        csr_wr_req    <= 1'b0;
                        csr_op        <= 2'b00;
                        csr_addr      <= '0;
                        csr_wdata     <= '0;
                        cnt_q         <= '0;
                        out_valid     <= 1'b1;
                        state_q       <= StResp;
                        if (csr_ack) begin
                            out_rdata    <= csr_rd_req ? csr_rdata : '0;
                            out_RegWrite <= rd_nz_q;
                            illegal_csr  <= 1'b0;
                            illegal_tval <= '0;
                        end else begin
                            out_rdata    <= '0;
                            out_RegWrite <= 1'b0;
                            illegal_csr  <= 1'b1;
                            illegal_tval <= instr_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        out_rdata    <= '0;
                        out_RegWrite <= 1'b0;
                        illegal_csr  <= 1'b0;
                        illegal_tval <= '0;
                        in_ready     <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CSR_ACCESS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_access  <= '0;
            stat_illegal <= '0;
        end else begin
            if (accept && (csr_ops != 2'b00)) begin
                stat_access <= stat_access + 32'd1;
            end
            if ((accept && (csr_ops != 2'b00) && dec_illegal) || timeout_fire) begin
                stat_illegal <= stat_illegal + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_csr_access_unit.sv
// Self-checking bench for m_csr_access_unit: vector table with response scoreboard, plus
// backpressure and reset-during-WAIT sequences.
module tb_m_csr_access_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AckTimeout = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [1:0]      csr_ops;
    logic [XLEN-1:0] rs1_data;
    logic            RegWrite_in;
    logic [1:0]      priv_mode;
    logic            csr_req_valid;
    logic            csr_rd_req;
    logic            csr_wr_req;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_ack;
    logic [XLEN-1:0] csr_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic            out_RegWrite;
    logic            illegal_csr;
    logic [31:0]     illegal_tval;
`ifdef CSR_ACCESS_STATS_EN
    logic [31:0]     stat_access;
    logic [31:0]     stat_illegal;
`endif

    m_csr_access_unit #(
        .XLEN        (XLEN),
        .ACK_TIMEOUT (AckTimeout)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .csr_ops       (csr_ops),
        .rs1_data      (rs1_data),
        .RegWrite_in   (RegWrite_in),
        .priv_mode     (priv_mode),
        .csr_req_valid (csr_req_valid),
        .csr_rd_req    (csr_rd_req),
        .csr_wr_req    (csr_wr_req),
        .csr_op        (csr_op),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_ack       (csr_ack),
        .csr_rdata     (csr_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_RegWrite  (out_RegWrite),
        .illegal_csr   (illegal_csr),
        .illegal_tval  (illegal_tval)
`ifdef CSR_ACCESS_STATS_EN
        ,
        .stat_access   (stat_access),
        .stat_illegal  (stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  ops;
        logic [11:0] addr;
        logic [4:0]  rs1f;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic        regwr_in;
        logic [1:0]  priv;
        int          ack_at;     // WAIT cycle carrying the ack, 0 = never
        logic [31:0] ack_rdata;
        logic        exp_req;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        int          exp_lat;    // cycles from accept edge to out_valid
        logic [31:0] exp_rdata;
        logic        exp_regwr;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        regwr;
        logic        ill;
        logic [31:0] tval;
    } resp_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t sb[$];
    vec_t  vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [11:0] addr, input logic [4:0] rs1f,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {addr, rs1f, f3, rd, 7'h73};
    endfunction

    task automatic drive(input vec_t v, input logic [31:0] instr);
        instruction = instr;
        csr_ops     = v.ops;
        rs1_data    = v.rs1_data;
        RegWrite_in = v.regwr_in;
        priv_mode   = v.priv;
        in_valid    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] instr;
        resp_t       r;
        resp_t       got;
        bit          seen;
        instr = mk(v.addr, v.rs1f, v.f3, v.rd);
        @(negedge clk);
        check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        drive(v, instr);
        r.rdata = v.exp_rdata;
        r.regwr = v.exp_regwr;
        r.ill   = v.exp_ill;
        r.tval  = v.exp_ill ? instr : 32'h0;
        sb.push_back(r);
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            csr_ack   = (v.ack_at == k);
            csr_rdata = (v.ack_at == k) ? v.ack_rdata : 32'hBAD0BAD0;
            if (out_valid) begin
                seen = 1'b1;
                check({v.name, " latency"}, 32'(k), 32'(v.exp_lat));
                check({v.name, " no req in RESP"}, 32'(csr_req_valid), 32'd0);
                if (sb.size() == 0) begin
                    check({v.name, " scoreboard nonempty"}, 32'd0, 32'd1);
                end else begin
                    got = sb.pop_front();
                    check({v.name, " out_rdata"}, out_rdata, got.rdata);
                    check({v.name, " out_RegWrite"}, 32'(out_RegWrite), 32'(got.regwr));
                    check({v.name, " illegal_csr"}, 32'(illegal_csr), 32'(got.ill));
                    check({v.name, " illegal_tval"}, illegal_tval, got.tval);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end else if (k == 1) begin
                check({v.name, " in_ready busy"}, 32'(in_ready), 32'd0);
                check({v.name, " req_valid"}, 32'(csr_req_valid), 32'(v.exp_req));
                if (v.exp_req) begin
                    check({v.name, " rd_req"}, 32'(csr_rd_req), 32'(v.exp_rd));
                    check({v.name, " wr_req"}, 32'(csr_wr_req), 32'(v.exp_wr));
                    check({v.name, " csr_op"}, 32'(csr_op), 32'(v.ops));
                    check({v.name, " csr_addr"}, 32'(csr_addr), 32'(v.addr));
                    check({v.name, " csr_wdata"}, csr_wdata, v.exp_wdata);
                end
            end
        end
        csr_ack = 1'b0;
        if (!seen) check({v.name, " response seen"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_acc;
        int exp_ilc;
        vec_t v;
        logic [31:0] instr;

        //         name              ops    addr    rs1f  f3      rd    rs1_data      rw  priv  ack rdata         req rd wr wdata         lat rdata         rw ill
        vecs[0]  = '{"csrrw_x0",      2'b01, 12'h340, 5'd1,  3'b001, 5'd0, 32'hDEADBEEF, 1'b1, 2'b11, 3, 32'h00000055, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 4, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{"csrrs_cycle_u", 2'b10, 12'hC00, 5'd0,  3'b010, 5'd5, 32'hAAAA0000, 1'b1, 2'b00, 1, 32'h00001234, 1'b1, 1'b1, 1'b0, 32'hAAAA0000, 2, 32'h00001234, 1'b1, 1'b0};
        vecs[2]  = '{"csrrw_ro",      2'b01, 12'hC00, 5'd1,  3'b001, 5'd3, 32'h00000001, 1'b1, 2'b11, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1, 32'h0,        1'b0, 1'b1};
        vecs[3]  = '{"csrrs_priv_u",  2'b10, 12'h300, 5'd2,  3'b010, 5'd1, 32'h00000004, 1'b1, 2'b00, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1, 32'h0,        1'b0, 1'b1};
        vecs[4]  = '{"csrrc_timeout", 2'b11, 12'h341, 5'd4,  3'b011, 5'd7, 32'h0F0F0F0F, 1'b1, 2'b11, 0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0F0F0F0F, 9, 32'h0,        1'b0, 1'b1};
        vecs[5]  = '{"csrrc_ack_last",2'b11, 12'h341, 5'd4,  3'b011, 5'd7, 32'h0F0F0F0F, 1'b1, 2'b11, 8, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 32'h0F0F0F0F, 9, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[6]  = '{"passthru_wr",   2'b00, 12'h005, 5'd0,  3'b000, 5'd1, 32'h0,        1'b1, 2'b11, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1, 32'h0,        1'b1, 1'b0};
        vecs[7]  = '{"csrrsi_s",      2'b10, 12'h100, 5'h1F, 3'b110, 5'd9, 32'hFFFFFFFF, 1'b1, 2'b01, 2, 32'h00000008, 1'b1, 1'b1, 1'b1, 32'h0000001F, 3, 32'h00000008, 1'b1, 1'b0};
        vecs[8]  = '{"csrrwi_priv_s", 2'b01, 12'h300, 5'd0,  3'b101, 5'd0, 32'hFFFFFFFF, 1'b1, 2'b01, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1, 32'h0,        1'b0, 1'b1};
        vecs[9]  = '{"csrrci_nowr",   2'b11, 12'h305, 5'd0,  3'b111, 5'd4, 32'hFFFFFFFF, 1'b1, 2'b11, 1, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h0,        2, 32'h80000000, 1'b1, 1'b0};
        vecs[10] = '{"passthru_nowr", 2'b00, 12'h000, 5'd0,  3'b000, 5'd0, 32'h0,        1'b0, 2'b00, 0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{"csrrs_mhartid", 2'b10, 12'hF14, 5'd0,  3'b010, 5'd2, 32'h0,        1'b1, 2'b11, 1, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        2, 32'h0,        1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; instruction = '0; csr_ops = 2'b00; rs1_data = '0;
        RegWrite_in = 1'b0; priv_mode = 2'b11; csr_ack = 1'b0; csr_rdata = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset req_valid", 32'(csr_req_valid), 32'd0);
        check("reset out_RegWrite", 32'(out_RegWrite), 32'd0);
        check("reset illegal", 32'(illegal_csr), 32'd0);
        check("reset tval", illegal_tval, 32'h0);
        check("reset rdata", out_rdata, 32'h0);
        rst = 1'b0;

        exp_acc = 0;
        exp_ilc = 0;
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].ops != 2'b00) exp_acc++;
            if (vecs[i].exp_ill) exp_ilc++;
        end
`ifdef CSR_ACCESS_STATS_EN
        @(negedge clk);
        check("stat_access", stat_access, 32'(exp_acc));
        check("stat_illegal", stat_illegal, 32'(exp_ilc));
`endif

        // Backpressure: result held while MEM stalls; stray ack in RESP has no effect.
        v = vecs[6];
        @(negedge clk);
        drive(v, 32'h00500093);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            csr_ack = 1'b1;
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_RegWrite", 32'(out_RegWrite), 32'd1);
            check("stall no req", 32'(csr_req_valid), 32'd0);
            if (i == 2) out_ready = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        csr_ack = 1'b0;
        @(negedge clk);
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain in_ready", 32'(in_ready), 32'd1);

        // Reset during WAIT aborts the access asynchronously with no response.
        v = vecs[0];
        instr = mk(v.addr, v.rs1f, v.f3, v.rd);
        drive(v, instr);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pre-reset req_valid", 32'(csr_req_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async rst req_valid", 32'(csr_req_valid), 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
`ifdef CSR_ACCESS_STATS_EN
        check("async rst stat_access", stat_access, 32'd0);
        check("async rst stat_illegal", stat_illegal, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[6]);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
